mandel_frame_scheduler: RTL and testbench

//  Sequences the Mandelbrot pixel engine over a full H_RES x V_RES frame in raster order.
//  For each pixel it computes c = (re, im), pulses the engine start, waits for the engine's

---
 rtl/mandel_pkg.sv | 30 +++
 rtl/mandel_coord_stepper.sv | 54 +++++
 rtl/mandel_frame_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mandel_frame_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot frame scheduler: FSM states, fixed-point coordinates,
// and the engine result payload.
package mandel_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned Q_FRAC  = 12;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0]        color_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } sched_state_t;

  typedef struct packed {
    logic   in_set;
    color_t color;
  } px_result_t;

  // Integer to Q4.12, wrapping modulo 2^COORD_W.
  function automatic coord_t to_q(input int v);
    return coord_t'(v <<< Q_FRAC);
  endfunction

endpackage

// File: rtl/mandel_coord_stepper.sv
// Raster-order pixel counters with matching complex-plane coordinate accumulators.
module mandel_coord_stepper
  import mandel_pkg::*;
#(
  parameter int unsigned H_RES = 64,
  parameter int unsigned V_RES = 48,
  parameter int unsigned XW    = $clog2(H_RES),
  parameter int unsigned YW    = $clog2(V_RES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  coord_t             x0,
  input  coord_t             y0,
  input  logic [COORD_W-1:0] step,
  output logic [XW-1:0]      col,
  output logic [YW-1:0]      row,
  output coord_t             re,
  output coord_t             im,
  output logic               last_pixel
);

  localparam logic [XW-1:0] COL_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(V_RES - 1);

  assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

  // Rows run top-down, so im decreases on each row wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      re  <= '0;
      im  <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
      re  <= x0;
      im  <= y0;
    end else if (advance && !last_pixel) begin
      if (col != COL_LAST) begin
        col <= col + XW'(1);
        re  <= re + coord_t'(step);
      end else begin
        col <= '0;
        re  <= x0;
        row <= row + YW'(1);
        im  <= im - coord_t'(step);
      end
    end
  end

endmodule

// File: rtl/mandel_frame_scheduler.sv
// Walks the pixel engine over one frame in raster order, with engine timeout and
// valid/ready hand-off of each result to the pixel writer.
module mandel_frame_scheduler
  import mandel_pkg::*;
#(
  parameter int unsigned H_RES       = 64,
  parameter int unsigned V_RES       = 48,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned XW          = $clog2(H_RES),
  parameter int unsigned YW          = $clog2(V_RES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  input  coord_t             cfg_x0,
  input  coord_t             cfg_y0,
  input  logic [COORD_W-1:0] cfg_step,
  input  logic               frame_start,
  input  logic               abort,
  output logic               eng_start,
  output coord_t             eng_cre,
  output coord_t             eng_cim,
  input  logic               eng_valid,
  input  logic               eng_in_set,
  input  color_t             eng_color,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [XW-1:0]      px_x,
  output logic [YW-1:0]      px_y,
  output color_t             px_color,
  output logic               px_in_set,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  sched_state_t       state_q, state_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  px_result_t         res_q, res_d;
  coord_t             cfg_x0_q, cfg_y0_q;
  logic [COORD_W-1:0] cfg_step_q;
  logic               timeout_err_d;
  logic               cfg_we, load, advance, last_pixel;
  coord_t             x0_in, y0_in;
  logic [COORD_W-1:0] step_in;

  mandel_coord_stepper #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .XW   (XW),
    .YW   (YW)
  ) u_stepper (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .advance   (advance),
    .x0        (x0_in),
    .y0        (y0_in),
    .step      (step_in),
    .col       (px_x),
    .row       (px_y),
    .re        (eng_cre),
    .im        (eng_cim),
    .last_pixel(last_pixel)
  );

  assign px_color  = res_q.color;
  assign px_in_set = res_q.in_set;

  // Next-state, datapath controls and registered-output next values.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    res_d         = res_q;
    timeout_err_d = timeout_err;
    cfg_we        = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cfg_we = cfg_valid;
        if (frame_start) begin
          state_d       = S_ISSUE;
          load          = 1'b1;
          timeout_err_d = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (eng_valid) begin
          state_d = S_EMIT;
          res_d   = '{in_set: eng_in_set, color: eng_color};
        end else if (tmo_q == TMO_LAST) begin
          state_d       = S_EMIT;
          res_d         = '0;
          timeout_err_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (px_ready) begin
          advance = !last_pixel;
          state_d = last_pixel ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else arriving in the same cycle.
    if (abort) begin
      state_d       = S_IDLE;
      tmo_d         = tmo_q;
      res_d         = res_q;
      timeout_err_d = timeout_err;
      cfg_we        = 1'b0;
      load          = 1'b0;
      advance       = 1'b0;
    end

    // A frame_start accompanied by cfg_valid runs on the new configuration.
    x0_in   = cfg_we ? cfg_x0   : cfg_x0_q;
    y0_in   = cfg_we ? cfg_y0   : cfg_y0_q;
    step_in = cfg_we ? cfg_step : cfg_step_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      res_q       <= '0;
      cfg_x0_q    <= '0;
      cfg_y0_q    <= '0;
      cfg_step_q  <= '0;
      eng_start   <= 1'b0;
      px_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      res_q       <= res_d;
      timeout_err <= timeout_err_d;
      eng_start   <= (state_d == S_ISSUE);
      px_valid    <= (state_d == S_EMIT);
      busy        <= (state_d != S_IDLE);
      frame_done  <= (state_d == S_DONE);
      if (cfg_we) begin
        cfg_x0_q   <= cfg_x0;
        cfg_y0_q   <= cfg_y0;
        cfg_step_q <= cfg_step;
      end
    end
  end

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Randomised bench for mandel_frame_scheduler on a 4x2 frame: an engine/ready model drives
// the DUT and a raster-order reference checks coordinates, results and frame timing.
module tb_mandel_frame_scheduler;

  localparam int H = 4;
  localparam int V = 2;
  localparam int NPIX = H * V;
  localparam int TMO = 16;

  logic        clk, reset;
  logic        cfg_valid, frame_start, abort;
  logic [15:0] cfg_x0, cfg_y0, cfg_step;
  logic        eng_start, eng_valid, eng_in_set;
  logic [15:0] eng_cre, eng_cim;
  logic [23:0] eng_color, px_color;
  logic        px_valid, px_ready, px_in_set;
  logic [1:0]  px_x;
  logic [0:0]  px_y;
  logic        busy, frame_done, timeout_err;

  mandel_frame_scheduler #(.H_RES(H), .V_RES(V), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_step(cfg_step), .frame_start(frame_start), .abort(abort), .eng_start(eng_start),
    .eng_cre(eng_cre), .eng_cim(eng_cim), .eng_valid(eng_valid), .eng_in_set(eng_in_set),
    .eng_color(eng_color), .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x),
    .px_y(px_y), .px_color(px_color), .px_in_set(px_in_set), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [15:0] cur_x0 = 0, cur_y0 = 0, cur_step = 0;
  logic [15:0] mx0, my0, mstep;
  bit          model_on = 0;
  int          midx = 0;
  int          frame_done_cnt = 0;
  int          last_hs_cyc = 0;
  logic [24:0] exp_res[$];
  logic [15:0] seen_re[$], seen_im[$];

  function automatic logic [15:0] exp_re(input int idx);
    return 16'(mx0 + 16'(idx % H) * mstep);
  endfunction
  function automatic logic [15:0] exp_im(input int idx);
    return 16'(my0 - 16'(idx / H) * mstep);
  endfunction

  // Engine model: decides each result at the start pulse, delivers it eng_lat cycles later
  int          eng_lat = 1;
  bit          eng_mute = 0;
  bit          eng_glitch = 0;
  int          spurious = 0;
  int          pend = 0;
  logic [24:0] pend_res;
  initial begin
    eng_valid = 0; eng_in_set = 0; eng_color = 0;
    forever begin
      @(posedge clk); #1;
      eng_valid  = 0;
      eng_in_set = 1'($urandom);
      eng_color  = 24'($urandom);
      if (spurious > 0) begin
        eng_valid = 1;
        spurious--;
      end else if (eng_start) begin
        if (eng_mute) begin
          exp_res.push_back(25'd0);
          pend = 0;
        end else begin
          pend_res = 25'($urandom);
          exp_res.push_back(pend_res);
          pend = eng_lat;
        end
        if (eng_glitch) eng_valid = 1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          {eng_in_set, eng_color} = pend_res;
          eng_valid = 1;
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  initial begin
    px_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       px_ready = 1;
        1:       px_ready = 1'($urandom);
        default: px_ready = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the raster reference
  bit          prev_start = 0, prev_pv = 0, prev_hs = 0;
  logic [27:0] held;
  logic [24:0] r;
  always @(negedge clk) begin
    if (reset) begin
      prev_start = 0; prev_pv = 0; prev_hs = 0;
    end else begin
      if (frame_done) frame_done_cnt++;
      if (model_on) begin
        if (eng_start || px_valid || frame_done) chk("busy", 32'(busy), 32'd1);
        if (prev_hs && midx < NPIX) chk("start_after_hs", 32'(eng_start), 32'd1);
        if (eng_start) begin
          chk("start_pulse", 32'(prev_start), 32'd0);
          chk("eng_cre", 32'(eng_cre), 32'(exp_re(midx)));
          chk("eng_cim", 32'(eng_cim), 32'(exp_im(midx)));
          seen_re.push_back(eng_cre);
          seen_im.push_back(eng_cim);
        end
        if (px_valid) begin
          chk("start_in_emit", 32'(eng_start), 32'd0);
          if (prev_pv && !prev_hs) chk("px_stable", 32'({px_x, px_y, px_in_set, px_color}), 32'(held));
          held = {px_x, px_y, px_in_set, px_color};
          if (px_ready) begin
            r = (exp_res.size() > 0) ? exp_res.pop_front() : 25'h1ffffff;
            chk("px_x", 32'(px_x), 32'(midx % H));
            chk("px_y", 32'(px_y), 32'(midx / H));
            chk("px_result", 32'({px_in_set, px_color}), 32'(r));
            midx++;
            last_hs_cyc = cyc;
          end
        end
        if (frame_done) begin
          chk("done_count", 32'(midx), 32'(NPIX));
          chk("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
          model_on = 0;
        end
      end else begin
        chk("idle_quiet", 32'({busy, eng_start, px_valid, frame_done}), 32'd0);
      end
      prev_start = eng_start;
      prev_pv    = px_valid;
      prev_hs    = px_valid && px_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit use_cfg, input logic [15:0] x0, input logic [15:0] y0,
                             input logic [15:0] step);
    @(posedge clk); #1;
    if (use_cfg) begin
      cfg_valid = 1; cfg_x0 = x0; cfg_y0 = y0; cfg_step = step;
      cur_x0 = x0; cur_y0 = y0; cur_step = step;
    end
    frame_start = 1;
    mx0 = cur_x0; my0 = cur_y0; mstep = cur_step;
    midx = 0;
    exp_res.delete();
    seen_re.delete();
    seen_im.delete();
    model_on = 1;
    tick(1);
    cfg_valid = 0; frame_start = 0;
  endtask

  task automatic hard_reset();
    reset = 1;
    tick(2);
    reset = 0;
    model_on = 0; pend = 0; spurious = 0;
    exp_res.delete();
    cur_x0 = 0; cur_y0 = 0; cur_step = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (model_on && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (model_on) begin
      checks++; errors++;
      $display("FAIL frame_timeout: frame_done not seen within %0d cycles, pixel %0d", budget, midx);
      hard_reset();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_eng_start"}, 32'(eng_start), 0);
    chk({tag, "_eng_cre"}, 32'(eng_cre), 0);
    chk({tag, "_eng_cim"}, 32'(eng_cim), 0);
    chk({tag, "_px_valid"}, 32'(px_valid), 0);
    chk({tag, "_px_xy"}, 32'({px_x, px_y}), 0);
    chk({tag, "_px_color"}, 32'(px_color), 0);
    chk({tag, "_px_in_set"}, 32'(px_in_set), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  logic [15:0] lit_re[NPIX] = '{16'hE000, 16'hE400, 16'hE800, 16'hEC00,
                                16'hE000, 16'hE400, 16'hE800, 16'hEC00};
  logic [15:0] lit_im[NPIX] = '{16'h1000, 16'h1000, 16'h1000, 16'h1000,
                                16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00};

  initial begin
    int n, s, e, fdc0;
    reset = 1; cfg_valid = 0; frame_start = 0; abort = 0;
    cfg_x0 = 0; cfg_y0 = 0; cfg_step = 0;
    hard_reset();
    @(negedge clk);
    check_all_zero("reset");

    // Directed frame: separate cfg load, engine latency 5, always ready
    @(posedge clk); #1;
    cfg_valid = 1; cfg_x0 = 16'hE000; cfg_y0 = 16'h1000; cfg_step = 16'h0400;
    cur_x0 = 16'hE000; cur_y0 = 16'h1000; cur_step = 16'h0400;
    tick(1);
    cfg_valid = 0;
    eng_lat = 5; rdy_mode = 0;
    fdc0 = frame_done_cnt;
    start_frame(0, 0, 0, 0);
    wait_done(300);
    chk("t1_pixels", 32'(seen_re.size()), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      chk("t1_re_lit", 32'((i < seen_re.size()) ? seen_re[i] : 16'hxxxx), 32'(lit_re[i]));
      chk("t1_im_lit", 32'((i < seen_im.size()) ? seen_im[i] : 16'hxxxx), 32'(lit_im[i]));
    end
    chk("t1_done_once", 32'(frame_done_cnt - fdc0), 32'd1);

    // Downstream stall in EMIT
    rdy_mode = 2; eng_lat = 2;
    start_frame(1, 16'($urandom), 16'($urandom), 16'($urandom));
    n = 0;
    @(negedge clk);
    while (!px_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(px_valid), 32'd1);
      chk("stall_no_start", 32'(eng_start), 32'd0);
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_done(300);

    // Engine silent on the first pixel
    eng_mute = 1; eng_lat = 1; rdy_mode = 0;
    start_frame(1, 16'($urandom), 16'($urandom), 16'($urandom));
    n = 0;
    @(negedge clk);
    while (!eng_start && n < 20) begin @(negedge clk); n++; end
    s = cyc;
    chk("tmo_err_before", 32'(timeout_err), 32'd0);
    eng_mute = 0;
    n = 0;
    while (!px_valid && n < 100) begin @(negedge clk); n++; end
    e = cyc;
    chk("tmo_latency", 32'(e - s), 32'(TMO + 1));
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    chk("tmo_color", 32'(px_color), 32'd0);
    wait_done(400);
    tick(2);
    @(negedge clk);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
    start_frame(0, 0, 0, 0);
    @(negedge clk);
    chk("tmo_err_cleared", 32'(timeout_err), 32'd0);
    wait_done(300);

    // Abort in WAIT of pixel 3, then restart from the top-left pixel
    eng_lat = 5; rdy_mode = 1;
    start_frame(1, 16'($urandom), 16'($urandom), 16'($urandom));
    n = 0;
    @(negedge clk);
    while (!(eng_start && midx == 3) && n < 300) begin @(negedge clk); n++; end
    chk("abort_at_px3", 32'(midx), 32'd3);
    @(posedge clk); #1;
    abort = 1;
    fdc0 = frame_done_cnt;
    @(posedge clk); #1;
    abort = 0;
    model_on = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_px_valid", 32'(px_valid), 32'd0);
    tick(10);
    chk("abort_no_done", 32'(frame_done_cnt - fdc0), 32'd0);
    pend = 0;
    exp_res.delete();
    start_frame(0, 0, 0, 0);
    wait_done(400);
    chk("abort_restart_re", 32'((seen_re.size() > 0) ? seen_re[0] : 16'hxxxx), 32'(cur_x0));

    // Same-cycle cfg+start with a wrapping step; mid-frame cfg/start ignored
    eng_lat = 1; rdy_mode = 0;
    start_frame(1, 16'h7C00, 16'h0123, 16'h0800);
    @(negedge clk);
    @(posedge clk); #1;
    cfg_valid = 1; cfg_x0 = 16'h1234; cfg_y0 = 16'h4321; cfg_step = 16'h0010; frame_start = 1;
    tick(1);
    cfg_valid = 0; frame_start = 0;
    wait_done(300);
    chk("wrap_re0", 32'((seen_re.size() > 0) ? seen_re[0] : 16'hxxxx), 32'h7C00);
    chk("wrap_re1", 32'((seen_re.size() > 1) ? seen_re[1] : 16'hxxxx), 32'h8400);
    start_frame(0, 0, 0, 0);
    wait_done(300);
    chk("cfg_kept", 32'((seen_re.size() > 0) ? seen_re[0] : 16'hxxxx), 32'h7C00);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      eng_lat = $urandom_range(1, 6);
      eng_glitch = 1'($urandom);
      rdy_mode = 1;
      start_frame(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_done(600);
    end
    eng_glitch = 0;

    // Reset while a pixel waits in EMIT
    rdy_mode = 2; eng_lat = 3;
    start_frame(1, 16'($urandom), 16'($urandom), 16'($urandom));
    n = 0;
    @(negedge clk);
    while (!px_valid && n < 50) begin @(negedge clk); n++; end
    chk("rst_in_emit", 32'(px_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    model_on = 0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 0;
    pend = 0;
    exp_res.delete();
    cur_x0 = 0; cur_y0 = 0; cur_step = 0;
    spurious = 3;
    tick(6);
    chk("rst_eng_ignored", 32'({px_valid, busy}), 32'd0);
    rdy_mode = 0; eng_lat = 2;
    start_frame(0, 0, 0, 0);
    wait_done(300);
    chk("rst_cfg_lost", 32'((seen_re.size() > 0) ? {seen_re[0], seen_im[0]} : 32'hxxxxxxxx), 32'd0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
